// File: rtl/mem_fifo_ctrl_pkg.sv
// mem_fifo_pkg
// Shared definitions for the memory-backed FIFO controller: the two-state
// output FSM encoding and the default word/address widths used by the
// interface, the pointer counter and the top level.
// Ports: none (package).
package mem_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 2;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // EMPTY: nothing on pop_data. VALID: pop_data carries the head word.
  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } fifo_state_e;

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// mem_fifo_ctrl_if
// Bundles the producer push handshake, the consumer pop handshake and the
// single-port memory bus of the FIFO controller.
//   push_valid/push_ready/push_data : producer side
//   pop_valid/pop_ready/pop_data    : consumer side
//   mem_wr/mem_re/mem_addr/mem_din  : strobes, address and write data to memory
//   mem_dout                        : registered read data from memory
// Modports: slave = the controller, master = the environment around it.
interface mem_fifo_ctrl_if
  import mem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  mem_wr;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  push_valid, push_data, pop_ready, mem_dout,
    output push_ready, pop_valid, pop_data, mem_wr, mem_re, mem_addr, mem_din
  );

  modport master (
    output push_valid, push_data, pop_ready, mem_dout,
    input  push_ready, pop_valid, pop_data, mem_wr, mem_re, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_fifo_ctrl_ptr.sv
// mem_fifo_ptr
// Wrapping address counter used for both the write and the read pointer.
// Counts 0 .. DEPTH-1 and wraps to 0, so non-power-of-two depths work too.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears ptr to 0
//   en  : advance the pointer by one this edge
//   ptr : current pointer value
module mem_fifo_ptr
  import mem_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH     = 1 << PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
// FIFO controller on top of an external single-port memory with registered
// read data. The head word is prefetched out of memory and presented on
// pop_data straight from mem_dout, so total occupancy is mem_count plus one
// while pop_valid is high. Reads take priority over writes on the shared port.
//   clk      : rising-edge clock, shared with the memory
//   rst      : synchronous active-high reset (contents are discarded)
//   bus      : mem_fifo_ctrl_if.slave (push/pop handshakes and memory bus)
// Optional (macro MEM_FIFO_CTRL_LEVEL_EN):
//   level    : registered total occupancy, mem_count + pop_valid
//   overflow : sticky flag, push attempted while the memory was full
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  mem_fifo_ctrl_if.slave    bus
`ifdef MEM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] level,
  output logic                overflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  fifo_state_e           state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  pop_valid_q;
  logic                  pop_hs;
  logic                  rd_issue;
  logic                  push_ok;
  logic                  wr_en;

  // Strobes and handshakes are masked while rst is high so nothing moves
  // during the reset cycle even though the state registers are not yet clear.
  assign pop_valid_q = (state == VALID) && !rst;
  assign pop_hs      = pop_valid_q && bus.pop_ready;
  assign rd_issue    = !rst && (mem_count != '0) && ((state == EMPTY) || pop_hs);
  assign push_ok     = !rst && !rd_issue && (mem_count < FULL_COUNT);
  assign wr_en       = bus.push_valid && push_ok;

  assign head_word    = bus.mem_dout;
  assign bus.pop_data   = head_word;
  assign bus.pop_valid  = pop_valid_q;
  assign bus.push_ready = push_ok;
  assign bus.mem_re     = rd_issue;
  assign bus.mem_wr     = wr_en;
  assign bus.mem_din    = bus.push_data;
  // Address idles on the write pointer and only switches for a read.
  assign bus.mem_addr   = rd_issue ? rd_ptr : wr_ptr;

  // Read and write are mutually exclusive, so at most one adjustment applies.
  always_comb begin
    count_next = mem_count;
    if (rd_issue) begin
      count_next = mem_count - (ADDR_WIDTH + 1)'(1);
    end else if (wr_en) begin
      count_next = mem_count + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_count <= '0;
    end else begin
      mem_count <= count_next;
    end
  end

  // A read issued now lands on mem_dout at the next edge, which is when the
  // head becomes valid; a pop without a refill leaves the output empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else if (rd_issue) begin
      state <= VALID;
    end else if (pop_hs) begin
      state <= EMPTY;
    end
  end

  mem_fifo_ptr #(
    .PTR_WIDTH (ADDR_WIDTH),
    .DEPTH     (MEM_DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .ptr (wr_ptr)
  );

  mem_fifo_ptr #(
    .PTR_WIDTH (ADDR_WIDTH),
    .DEPTH     (MEM_DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_issue),
    .ptr (rd_ptr)
  );

`ifdef MEM_FIFO_CTRL_LEVEL_EN
  logic valid_next;

  // Mirror the next-state decision so level tracks mem_count + pop_valid
  // in the same cycle rather than one cycle late.
  assign valid_next = rd_issue || ((state == VALID) && !pop_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level <= count_next + (ADDR_WIDTH + 1)'(valid_next);
      if (bus.push_valid && (mem_count == FULL_COUNT)) begin
        overflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl
// Self-checking bench for mem_fifo_ctrl (DATA_WIDTH=2, ADDR_WIDTH=2).
// A behavioural single-port memory with registered read data sits on the
// memory side. Inputs change on the falling edge; outputs are checked 1ns
// later, i.e. well before the next rising edge.
module tb_mem_fifo_ctrl;

  typedef struct {
    logic       pv;
    logic [1:0] pd;
    logic       pr;
    logic       expPushReady;
    logic       expPopValid;
    logic [1:0] expPopData;
    logic       expWr;
    logic       expRe;
    logic [1:0] expAddr;
  } vec_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  logic [1:0] memModel [0:3];

`ifdef MEM_FIFO_CTRL_LEVEL_EN
  logic [2:0] level;
  logic       overflow;
`endif

  mem_fifo_ctrl_if #(.DATA_WIDTH(2), .ADDR_WIDTH(2)) bus ();

  mem_fifo_ctrl #(
    .DATA_WIDTH (2),
    .ADDR_WIDTH (2),
    .MEM_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    ,
    .level    (level),
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on mem_wr, registered read on mem_re.
  always @(posedge clk) begin
    if (bus.mem_wr) memModel[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_re) bus.mem_dout <= memModel[bus.mem_addr];
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic pv, input logic [1:0] pd,
                               input logic pr);
    @(negedge clk);
    rst            = r;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  vec_t vecs [0:24];

  initial begin
    logic [1:0] expPtr;
    logic [1:0] d;
    testsRun    = 0;
    testsFailed = 0;

    // {pv, pd, pr, push_ready, pop_valid, pop_data, mem_wr, mem_re, mem_addr}
    // Single word through an empty FIFO.
    vecs[0]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1};
    // Fill with pop_ready low: 0,1,2,3,0 then full.
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd2};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd3};
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd2};
    // Drain with pop_ready high: expect 0,1,2,3,0.
    vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd2};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd3};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd2};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2};
    // Read/write conflict: pop handshake with mem_count>0 stalls the push.
    vecs[17] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2};
    vecs[18] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2};
    vecs[19] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd3};
    vecs[20] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd3};
    vecs[21] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0};
    vecs[22] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[23] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1};
    vecs[24] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1};

    // Reset: outputs quiet while rst is held, even with both handshakes offered.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
    checkOutput("reset pop_valid", 32'(bus.pop_valid), 32'd0);
    checkOutput("reset mem_wr",    32'(bus.mem_wr),    32'd0);
    checkOutput("reset mem_re",    32'(bus.mem_re),    32'd0);

    for (int i = 0; i <= 24; i++) begin
      applyStimulus(1'b0, vecs[i].pv, vecs[i].pd, vecs[i].pr);
      checkOutput($sformatf("vec%0d push_ready", i), 32'(bus.push_ready), 32'(vecs[i].expPushReady));
      checkOutput($sformatf("vec%0d pop_valid", i),  32'(bus.pop_valid),  32'(vecs[i].expPopValid));
      if (vecs[i].expPopValid)
        checkOutput($sformatf("vec%0d pop_data", i), 32'(bus.pop_data), 32'(vecs[i].expPopData));
      checkOutput($sformatf("vec%0d mem_wr", i),   32'(bus.mem_wr),   32'(vecs[i].expWr));
      checkOutput($sformatf("vec%0d mem_re", i),   32'(bus.mem_re),   32'(vecs[i].expRe));
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].expAddr));
    end

    // Wrap: ten push/pop pairs starting with both pointers at 1.
    expPtr = 2'd1;
    for (int i = 0; i < 10; i++) begin
      d = 2'(i * 3 + 1);
      applyStimulus(1'b0, 1'b1, d, 1'b1);
      checkOutput($sformatf("wrap%0d push_ready", i), 32'(bus.push_ready), 32'd1);
      checkOutput($sformatf("wrap%0d wr_addr", i), 32'({bus.mem_wr, bus.mem_addr}), 32'({1'b1, expPtr}));
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
      checkOutput($sformatf("wrap%0d rd_addr", i), 32'({bus.mem_re, bus.mem_addr}), 32'({1'b1, expPtr}));
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
      checkOutput($sformatf("wrap%0d pop_valid", i), 32'(bus.pop_valid), 32'd1);
      checkOutput($sformatf("wrap%0d pop_data", i),  32'(bus.pop_data),  32'(d));
      expPtr = expPtr + 2'd1;
    end

    // Reset mid-stream: both pointers at 3, hold three words, then reset.
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
    checkOutput("midrst held pop_valid", 32'(bus.pop_valid), 32'd1);
    checkOutput("midrst held pop_data",  32'(bus.pop_data),  32'd1);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
    checkOutput("midrst during pop_valid", 32'(bus.pop_valid), 32'd0);
    checkOutput("midrst during mem_re",    32'(bus.mem_re),    32'd0);
    checkOutput("midrst during mem_wr",    32'(bus.mem_wr),    32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput("midrst after pop_valid",  32'(bus.pop_valid),  32'd0);
    checkOutput("midrst after push_ready", 32'(bus.push_ready), 32'd1);
    checkOutput("midrst after mem_re",     32'(bus.mem_re),     32'd0);
    checkOutput("midrst after mem_addr",   32'(bus.mem_addr),   32'd0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
    checkOutput("midrst push wr_addr", 32'({bus.mem_wr, bus.mem_addr}), 32'({1'b1, 2'd0}));
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput("midrst push rd_addr", 32'({bus.mem_re, bus.mem_addr}), 32'({1'b1, 2'd0}));
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput("midrst pop_valid", 32'(bus.pop_valid), 32'd1);
    checkOutput("midrst pop_data",  32'(bus.pop_data),  32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkOutput("midrst drained pop_valid", 32'(bus.pop_valid), 32'd0);
    checkOutput("midrst drained mem_re",    32'(bus.mem_re),    32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
